// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: shared definitions for the prefetch queue and decode.
//   DEPTH                  byte capacity of the circular buffer (power of two)
//   instruction_window_len bytes presented to decode per cycle
//   fetch_bytes            bytes carried by one fetch word
package prefetch_queue_pkg;

  localparam int DEPTH                  = 16;
  localparam int instruction_window_len = 10;
  localparam int fetch_bytes            = 4;
  localparam int PTR_W                  = $clog2(DEPTH);
  localparam int CNT_W                  = PTR_W + 1;

  typedef logic [7:0]       byte_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Bytes visible to decode: min(count, window length).
  function automatic logic [3:0] clamp_window(input cnt_t c);
    if (c > cnt_t'(instruction_window_len))
      return 4'(instruction_window_len);
    return c[3:0];
  endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if: fetch/consume/window bundle between the fetch unit,
// decode and the prefetch queue.
//   master: fetch unit + decode side (drives fetch and consume requests)
//   slave : prefetch queue (drives fetch_ready, window and error pulse)
interface prefetch_queue_if;
  import prefetch_queue_pkg::*;

  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [1:0]  fetch_skip;
  byte_t       instruction [0:instruction_window_len-1];
  logic [3:0]  window_count;
  logic        consume_valid;
  logic [3:0]  consume_len;
  logic        consume_error;

  modport master (
    output flush, fetch_valid, fetch_data, fetch_skip, consume_valid, consume_len,
    input  fetch_ready, instruction, window_count, consume_error
  );

  modport slave (
    input  flush, fetch_valid, fetch_data, fetch_skip, consume_valid, consume_len,
    output fetch_ready, instruction, window_count, consume_error
  );

endinterface

// File: rtl/prefetch_queue_window.sv
// prefetch_queue_window: combinational rotator presenting the oldest queued
// bytes to decode, zero-filled beyond the valid count.
//   mem_i          circular byte buffer contents
//   rd_ptr_i       index of the oldest byte
//   count_i        number of valid bytes in the buffer
//   instruction_o  window, [0] = oldest byte
//   window_count_o min(count, window length)
module prefetch_queue_window
  import prefetch_queue_pkg::*;
(
  input  byte_t      mem_i [DEPTH],
  input  ptr_t       rd_ptr_i,
  input  cnt_t       count_i,
  output byte_t      instruction_o [0:instruction_window_len-1],
  output logic [3:0] window_count_o
);

  always_comb begin
    for (int i = 0; i < instruction_window_len; i++) begin
      instruction_o[i] = 8'h00;
      // Index wraps naturally in PTR_W bits, so a straddling window is contiguous.
      if (cnt_t'(i) < count_i)
        instruction_o[i] = mem_i[rd_ptr_i + ptr_t'(i)];
    end
  end

  assign window_count_o = clamp_window(count_i);

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-granular instruction prefetch queue.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  prefetch_queue_if.slave: fetch words in, 10-byte window out,
//        consume requests in, registered consume_error pulse out
module prefetch_queue
  import prefetch_queue_pkg::*;
(
  input logic             clk,
  input logic             rst,
  prefetch_queue_if.slave bus
);

  byte_t mem_q [DEPTH];
  ptr_t  rd_ptr_q, rd_ptr_d;
  ptr_t  wr_ptr_q, wr_ptr_d;
  cnt_t  count_q,  count_d;
  logic  err_q,    err_d;

  byte_t      win [0:instruction_window_len-1];
  logic [3:0] win_count;
  logic       do_write;
  logic       consume_ok;
  cnt_t       wr_n;
  cnt_t       rd_n;
  logic       wr_en  [fetch_bytes];
  ptr_t       wr_idx [fetch_bytes];

  prefetch_queue_window u_window (
    .mem_i          (mem_q),
    .rd_ptr_i       (rd_ptr_q),
    .count_i        (count_q),
    .instruction_o  (win),
    .window_count_o (win_count)
  );

  assign bus.instruction   = win;
  assign bus.window_count  = win_count;
  assign bus.consume_error = err_q;

  // Credit comes from the registered count only; a same-edge consume does not help.
  assign bus.fetch_ready = (cnt_t'(DEPTH) - count_q) >= cnt_t'(fetch_bytes);

  assign do_write   = bus.fetch_valid & bus.fetch_ready & ~bus.flush;
  // window_count never exceeds the window length, so this also rejects len > 10.
  assign consume_ok = bus.consume_valid && (bus.consume_len != 4'd0)
                      && (bus.consume_len <= win_count);

  assign wr_n = do_write   ? cnt_t'(3'(fetch_bytes) - {1'b0, bus.fetch_skip}) : '0;
  assign rd_n = consume_ok ? cnt_t'(bus.consume_len) : '0;

  // Skipped leading bytes are dropped; the rest pack down starting at wr_ptr.
  always_comb begin
    for (int i = 0; i < fetch_bytes; i++) begin
      wr_en[i]  = do_write && (i >= int'(bus.fetch_skip));
      wr_idx[i] = wr_ptr_q + ptr_t'(i) - ptr_t'(bus.fetch_skip);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = 1'b0;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write)
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_n);
      if (consume_ok)
        rd_ptr_d = rd_ptr_q + bus.consume_len;
      count_d = count_q + wr_n - rd_n;
      err_d   = bus.consume_valid & ~consume_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; bytes beyond count are masked by the window.
  always_ff @(posedge clk) begin
    for (int i = 0; i < fetch_bytes; i++) begin
      if (wr_en[i])
        mem_q[wr_idx[i]] <= bus.fetch_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;
  import prefetch_queue_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prefetch_queue_if pif ();

  prefetch_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        flush;
    logic        fv;
    logic [31:0] data;
    logic [1:0]  skip;
    logic        cv;
    logic [3:0]  len;
    logic        exp_ready;
    logic [3:0]  exp_wc;
    logic        exp_err;
    logic [79:0] exp_win;
  } vec_t;

  vec_t vq[$];

  function automatic logic [79:0] get_win();
    logic [79:0] w;
    for (int i = 0; i < instruction_window_len; i++)
      w[8*i +: 8] = pif.instruction[i];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [31:0] d,
                       input logic [1:0] sk, input logic cv, input logic [3:0] ln);
    pif.flush         = fl;
    pif.fetch_valid   = fv;
    pif.fetch_data    = d;
    pif.fetch_skip    = sk;
    pif.consume_valid = cv;
    pif.consume_len   = ln;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic fv, input logic [31:0] d, input logic [1:0] sk,
                     input logic cv, input logic [3:0] ln, input logic r, input logic [3:0] wc,
                     input logic e, input logic [79:0] w);
    vec_t v;
    v.flush = fl; v.fv = fv; v.data = d; v.skip = sk; v.cv = cv; v.len = ln;
    v.exp_ready = r; v.exp_wc = wc; v.exp_err = e; v.exp_win = w;
    vq.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic r, input logic [3:0] wc,
                         input logic e, input logic [79:0] w);
    chk({tag, " ready"}, 80'(pif.fetch_ready), 80'(r));
    chk({tag, " wcount"}, 80'(pif.window_count), 80'(wc));
    chk({tag, " err"}, 80'(pif.consume_error), 80'(e));
    chk({tag, " window"}, get_win(), w);
  endtask

  initial begin
    int next_w, cons, mcount, li, cyc, len, exp_wc;
    logic fv, cv;
    logic [31:0] d;
    logic [79:0] ew;
    int lens [4];

    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 0, 32'h0, 2'd0, 0, 4'd0);
    #1;
    chk_all("reset", 1'b1, 4'd0, 1'b0, 80'h0);
    #1 rst = 1'b0;

    //  flush fv data         skip cv len  rdy wc  err window
    add(0, 1, 32'h00010E89, 0, 0, 0,   1, 4,  0, 80'h00010E89);
    add(0, 1, 32'h00000001, 0, 0, 0,   1, 8,  0, 80'h00000000000100010E89);
    add(0, 0, 32'h0,        0, 1, 4,   1, 4,  0, 80'h00000000000000000001);
    add(1, 0, 32'h0,        0, 1, 4,   1, 0,  0, 80'h0);
    add(0, 1, 32'h0FA80F00, 1, 0, 0,   1, 3,  0, 80'h0FA80F);
    add(0, 0, 32'h0,        0, 1, 5,   1, 3,  1, 80'h0FA80F);
    add(0, 0, 32'h0,        0, 0, 0,   1, 3,  0, 80'h0FA80F);
    add(0, 0, 32'h0,        0, 1, 0,   1, 3,  1, 80'h0FA80F);
    add(0, 0, 32'h0,        0, 1, 11,  1, 3,  1, 80'h0FA80F);
    add(0, 0, 32'h0,        0, 1, 3,   1, 0,  0, 80'h0);
    add(0, 1, 32'h03020100, 0, 0, 0,   1, 4,  0, 80'h03020100);
    add(0, 1, 32'h07060504, 0, 0, 0,   1, 8,  0, 80'h0706050403020100);
    add(0, 1, 32'h0B0A0908, 0, 0, 0,   1, 10, 0, 80'h09080706050403020100);
    add(0, 1, 32'h0F0E0D0C, 0, 0, 0,   0, 10, 0, 80'h09080706050403020100);
    add(0, 1, 32'h13121110, 0, 1, 4,   1, 10, 0, 80'h0D0C0B0A090807060504);
    add(0, 1, 32'h13121110, 0, 0, 0,   0, 10, 0, 80'h0D0C0B0A090807060504);
    add(0, 1, 32'h17161514, 0, 0, 0,   0, 10, 0, 80'h0D0C0B0A090807060504);
    add(0, 0, 32'h0,        0, 1, 10,  1, 6,  0, 80'h00000000131211100F0E);
    add(0, 1, 32'h17161514, 2, 1, 6,   1, 2,  0, 80'h1716);

    foreach (vq[k]) begin
      drive(vq[k].flush, vq[k].fv, vq[k].data, vq[k].skip, vq[k].cv, vq[k].len);
      step();
      chk_all($sformatf("vec%0d", k), vq[k].exp_ready, vq[k].exp_wc, vq[k].exp_err, vq[k].exp_win);
    end

    // Streaming across pointer wraps with consume lengths 1,3,7,10.
    drive(1, 0, 32'h0, 2'd0, 0, 4'd0);
    step();
    lens = '{1, 3, 7, 10};
    next_w = 0; cons = 0; mcount = 0; li = 0; cyc = 0;
    while (cons < 40 && cyc < 300) begin
      fv = (mcount <= 12) && (next_w < 40);
      for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(next_w + b);
      cv = 1'b0;
      len = 0;
      if (mcount >= lens[li]) begin
        cv = 1'b1; len = lens[li];
      end else if (next_w >= 40 && mcount > 0) begin
        cv = 1'b1; len = mcount;
      end
      drive(0, fv, d, 2'd0, cv, 4'(len));
      step();
      if (fv) begin next_w += 4; mcount += 4; end
      if (cv) begin cons += len; mcount -= len; li = (li + 1) % 4; end
      exp_wc = (mcount > 10) ? 10 : mcount;
      ew = '0;
      for (int i = 0; i < exp_wc; i++) ew[8*i +: 8] = 8'(cons + i);
      chk_all($sformatf("stream%0d", cyc), mcount <= 12, 4'(exp_wc), 1'b0, ew);
      cyc++;
    end
    chk("stream done", 80'(cons >= 40), 80'(1));

    // Asynchronous reset between edges with an error pulse pending.
    drive(0, 1, 32'h00010E89, 2'd0, 0, 4'd0);
    step();
    drive(0, 0, 32'h0, 2'd0, 1, 4'd9);
    step();
    chk("pre-reset err", 80'(pif.consume_error), 80'(1));
    chk("pre-reset wcount", 80'(pif.window_count), 80'(4));
    drive(0, 0, 32'h0, 2'd0, 0, 4'd0);
    #2 rst = 1'b1;
    #1;
    chk_all("async reset", 1'b1, 4'd0, 1'b0, 80'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'h00010E89, 2'd0, 0, 4'd0);
    step();
    chk_all("post reset", 1'b1, 4'd4, 1'b0, 80'h00010E89);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
